// File: rtl/std_cache_pkg.sv
// Shared cache-side types for the commit store queue: entry layout,
// default depth and the drain FSM state encoding.
package std_cache_pkg;

  localparam int SQ_DEPTH_DEFAULT = 8;
  localparam int SQ_ADDR_W        = 64;
  localparam int SQ_DATA_W        = 64;
  localparam int SQ_BE_W          = SQ_DATA_W / 8;

  // Entries are stored at the widest supported geometry; narrower queues
  // zero-extend on write and slice on read.
  typedef struct packed {
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
    logic [SQ_BE_W-1:0]   be;
  } sq_entry_t;

  typedef enum logic {
    SQ_IDLE = 1'b0,
    SQ_REQ  = 1'b1
  } sq_drain_e;

endpackage

// File: rtl/commit_store_queue_fwd.sv
// Per-entry page-offset comparators for store-to-load forwarding hits.
// Only instantiated when CVA6_SQ_FWD_EN is defined.
module commit_store_queue_fwd #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]      vld,
  input  logic [DEPTH-1:0][8:0] off,
  input  logic [8:0]            ld_off,
  output logic                  hit
);

  logic [DEPTH-1:0] match;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign match[g] = vld[g] && (off[g] == ld_off);
  end

  assign hit = |match;

endmodule

// File: rtl/commit_store_queue.sv
// Commit store queue: speculative stores are pushed, committed in order,
// then drained to the write-back cache through a req/gnt handshake.
// Optional feature macro: CVA6_SQ_FWD_EN adds a load-address forwarding
// hit output (ld_addr_i / fwd_hit_o).
module commit_store_queue
  import std_cache_pkg::*;
#(
  parameter int DEPTH  = SQ_DEPTH_DEFAULT,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic                commit_i,
  output logic                commit_ready_o,
  output logic                req_o,
  input  logic                gnt_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [DATA_W/8-1:0] be_o,
  output logic                empty_o
`ifdef CVA6_SQ_FWD_EN
  ,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  output logic                fwd_hit_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PW    = IDX_W + 1;

  // rd..cm = committed, cm..wr = speculative; MSB is the wrap bit.
  logic [PW-1:0] rd_ptr, cm_ptr, wr_ptr;
  logic [PW-1:0] comm_cnt, spec_cnt, total_cnt, comm_next;
  sq_entry_t     mem [DEPTH];
  sq_entry_t     head;
  sq_drain_e     state;
  logic          push, commit, drain;

  assign comm_cnt  = cm_ptr - rd_ptr;
  assign spec_cnt  = wr_ptr - cm_ptr;
  assign total_cnt = wr_ptr - rd_ptr;

  assign ready_o        = total_cnt < PW'(DEPTH);
  assign commit_ready_o = spec_cnt != '0;
  assign req_o          = state == SQ_REQ;
  assign empty_o        = rd_ptr == wr_ptr;

  assign push   = valid_i && ready_o && !flush_i;
  assign commit = commit_i && commit_ready_o;
  assign drain  = req_o && gnt_i;

  // Committed count after this edge; lets req_o rise the cycle after a commit.
  assign comm_next = comm_cnt + PW'(commit) - PW'(drain);

  assign head   = mem[rd_ptr[IDX_W-1:0]];
  assign addr_o = head.addr[ADDR_W-1:0];
  assign data_o = head.data[DATA_W-1:0];
  assign be_o   = head.be[DATA_W/8-1:0];

  // Pointer update and drain FSM; flush rolls wr back to the post-commit cm.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      cm_ptr <= '0;
      wr_ptr <= '0;
      state  <= SQ_IDLE;
    end else begin
      rd_ptr <= rd_ptr + PW'(drain);
      cm_ptr <= cm_ptr + PW'(commit);
      wr_ptr <= flush_i ? (cm_ptr + PW'(commit)) : (wr_ptr + PW'(push));
      case (state)
        SQ_IDLE: if (comm_next != '0) state <= SQ_REQ;
        SQ_REQ:  if (gnt_i && comm_next == '0) state <= SQ_IDLE;
        default: state <= SQ_IDLE;
      endcase
    end
  end

  // Entry storage is never reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[IDX_W-1:0]].addr <= SQ_ADDR_W'(addr_i);
      mem[wr_ptr[IDX_W-1:0]].data <= SQ_DATA_W'(data_i);
      mem[wr_ptr[IDX_W-1:0]].be   <= SQ_BE_W'(be_i);
    end
  end

`ifdef CVA6_SQ_FWD_EN
  logic [DEPTH-1:0]      ent_vld;
  logic [DEPTH-1:0][8:0] ent_off;

  // An entry is live when its distance from the head is below the total count.
  always_comb begin
    ent_vld = '0;
    ent_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [IDX_W-1:0] dist;
      dist       = IDX_W'(i) - rd_ptr[IDX_W-1:0];
      ent_vld[i] = {1'b0, dist} < total_cnt;
      ent_off[i] = mem[i].addr[11:3];
    end
  end

  commit_store_queue_fwd #(.DEPTH(DEPTH)) u_fwd (
    .vld    (ent_vld),
    .off    (ent_off),
    .ld_off (ld_addr_i[11:3]),
    .hit    (fwd_hit_o)
  );
`endif

endmodule

// File: tb/tb_commit_store_queue.sv
// Directed bench for commit_store_queue (DEPTH=8, 64-bit address/data).
module tb_commit_store_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i, valid_i, ready_o, commit_i, commit_ready_o;
  logic        req_o, gnt_i, empty_o;
  logic [63:0] addr_i, data_i, addr_o, data_o;
  logic [7:0]  be_i, be_o;
`ifdef CVA6_SQ_FWD_EN
  logic [63:0] ld_addr_i;
  logic        fwd_hit_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  commit_store_queue #(.DEPTH(8), .ADDR_W(64), .DATA_W(64)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .addr_i         (addr_i),
    .data_i         (data_i),
    .be_i           (be_i),
    .commit_i       (commit_i),
    .commit_ready_o (commit_ready_o),
    .req_o          (req_o),
    .gnt_i          (gnt_i),
    .addr_o         (addr_o),
    .data_o         (data_o),
    .be_o           (be_o),
    .empty_o        (empty_o)
`ifdef CVA6_SQ_FWD_EN
    ,
    .ld_addr_i      (ld_addr_i),
    .fwd_hit_o      (fwd_hit_o)
`endif
  );

  function automatic logic [63:0] data_of(input logic [63:0] a);
    return ~a;
  endfunction

  function automatic logic [7:0] be_of(input logic [63:0] a);
    return a[10:3];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; commit_i = 1'b0; gnt_i = 1'b0;
    addr_i = '0; data_i = '0; be_i = '0;
`ifdef CVA6_SQ_FWD_EN
    ld_addr_i = '0;
`endif
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic push_entry(input logic [63:0] a);
    valid_i = 1'b1; addr_i = a; data_i = data_of(a); be_i = be_of(a);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_ni = 1'b0;
    tick();
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b exp 1", ready_o); end
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_commit_ready: got %0b exp 0", commit_ready_o); end
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b exp 0", req_o); end
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %0b exp 1", empty_o); end
    rst_ni = 1'b1;
    tick();
    n_checks++; if (ready_o !== 1'b1 || empty_o !== 1'b1 || req_o !== 1'b0) begin
      n_fail++; $display("FAIL post_rst: ready %0b empty %0b req %0b exp 1 1 0", ready_o, empty_o, req_o);
    end
  endtask

  task automatic test_basic_drain();
    logic [63:0] exp_a [3];
    exp_a[0] = 64'h8000_0000; exp_a[1] = 64'h8000_0008; exp_a[2] = 64'h8000_0010;
    do_reset();
    gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) push_entry(exp_a[i]);
    n_checks++; if (commit_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_commit_ready: got %0b exp 1", commit_ready_o); end
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL basic_req_early: got %0b exp 0", req_o); end
    commit_i = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      commit_i = (k < 2);
      n_checks++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL basic_req%0d: got %0b exp 1", k, req_o); end
      n_checks++; if (addr_o !== exp_a[k]) begin n_fail++; $display("FAIL basic_addr%0d: got %0h exp %0h", k, addr_o, exp_a[k]); end
      n_checks++; if (data_o !== data_of(exp_a[k])) begin n_fail++; $display("FAIL basic_data%0d: got %0h exp %0h", k, data_o, data_of(exp_a[k])); end
      tick();
    end
    commit_i = 1'b0;
    gnt_i = 1'b0;
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL basic_req_end: got %0b exp 0", req_o); end
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %0b exp 1", empty_o); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready%0d: got %0b exp 1", i, ready_o); end
      push_entry(64'h4000 + 64'(i) * 8);
    end
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b exp 0", ready_o); end
    n_checks++; if (commit_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_commit_ready: got %0b exp 1", commit_ready_o); end
    push_entry(64'hdead_0000);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ninth: ready got %0b exp 0", ready_o); end
    n_checks++; if (empty_o !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %0b exp 0", empty_o); end
  endtask

  task automatic test_flush();
    do_reset();
    gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) push_entry(64'h100 + 64'(i) * 8);
    commit_i = 1'b1; flush_i = 1'b1; valid_i = 1'b1; addr_i = 64'h999;
    tick();
    commit_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_commit_ready: got %0b exp 0", commit_ready_o); end
    n_checks++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL flush_req: got %0b exp 1", req_o); end
    n_checks++; if (addr_o !== 64'h100) begin n_fail++; $display("FAIL flush_addr: got %0h exp 100", addr_o); end
    tick();
    gnt_i = 1'b0;
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL flush_req_end: got %0b exp 0", req_o); end
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %0b exp 1", empty_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b exp 1", ready_o); end
  endtask

  task automatic test_stall();
    do_reset();
    push_entry(64'h200);
    push_entry(64'h208);
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL stall_req%0d: got %0b exp 1", c, req_o); end
      n_checks++; if (addr_o !== 64'h200 || data_o !== data_of(64'h200) || be_o !== be_of(64'h200)) begin
        n_fail++; $display("FAIL stall_payload%0d: got %0h/%0h/%0h exp 200/%0h/%0h", c, addr_o, data_o, be_o, data_of(64'h200), be_of(64'h200));
      end
      tick();
    end
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req_after_gnt: got %0b exp 0", req_o); end
    n_checks++; if (commit_ready_o !== 1'b1 || empty_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_state: commit_ready %0b empty %0b exp 1 0", commit_ready_o, empty_o);
    end
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    n_checks++; if (req_o !== 1'b1 || addr_o !== 64'h208) begin
      n_fail++; $display("FAIL stall_next_head: req %0b addr %0h exp 1 208", req_o, addr_o);
    end
    // reset while a drain request is pending
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    n_checks++; if (req_o !== 1'b0 || empty_o !== 1'b1 || ready_o !== 1'b1) begin
      n_fail++; $display("FAIL stall_mid_reset: req %0b empty %0b ready %0b exp 0 1 1", req_o, empty_o, ready_o);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [63:0] sb [$];
    logic [63:0] nxt, exp_a;
    logic        exp_ready, do_push, do_commit, do_drain;
    int          comm, spec, pushed, drained, cyc;
    do_reset();
    nxt = 64'h1000;
    for (int i = 0; i < 8; i++) begin
      push_entry(nxt);
      sb.push_back(nxt);
      nxt += 8;
    end
    comm = 0; spec = 8; pushed = 0; drained = 0; cyc = 0;
    commit_i = 1'b1; gnt_i = 1'b1;
    while ((pushed < 20 || !empty_o) && cyc < 200) begin
      valid_i = (pushed < 20);
      addr_i = nxt; data_i = data_of(nxt); be_i = be_of(nxt);
      exp_ready = (comm + spec) < 8;
      n_checks++; if (ready_o !== exp_ready) begin n_fail++; $display("FAIL wrap_ready c%0d: got %0b exp %0b", cyc, ready_o, exp_ready); end
      n_checks++; if (commit_ready_o !== (spec > 0)) begin n_fail++; $display("FAIL wrap_commit_ready c%0d: got %0b exp %0b", cyc, commit_ready_o, spec > 0); end
      do_push = valid_i && exp_ready;
      do_commit = spec > 0;
      do_drain = req_o;
      if (do_drain) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL wrap_extra_drain c%0d: addr %0h with empty scoreboard", cyc, addr_o);
        end else begin
          exp_a = sb.pop_front();
          if (addr_o !== exp_a) begin n_fail++; $display("FAIL wrap_order c%0d: got %0h exp %0h", cyc, addr_o, exp_a); end
        end
        drained++;
      end
      if (do_push) begin
        sb.push_back(nxt);
        nxt += 8;
        pushed++;
      end
      comm += int'(do_commit) - int'(do_drain);
      spec += int'(do_push) - int'(do_commit);
      tick();
      cyc++;
    end
    valid_i = 1'b0; commit_i = 1'b0; gnt_i = 1'b0;
    n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL wrap_timeout: cycles %0d limit 200", cyc); end
    n_checks++; if (drained != 28) begin n_fail++; $display("FAIL wrap_count: got %0d exp 28", drained); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL wrap_leftover: got %0d exp 0", sb.size()); end
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %0b exp 1", empty_o); end
  endtask

`ifdef CVA6_SQ_FWD_EN
  task automatic test_fwd();
    do_reset();
    ld_addr_i = 64'h9000_0238;
    #1;
    n_checks++; if (fwd_hit_o !== 1'b0) begin n_fail++; $display("FAIL fwd_empty: got %0b exp 0", fwd_hit_o); end
    push_entry(64'h8000_1238);
    n_checks++; if (fwd_hit_o !== 1'b1) begin n_fail++; $display("FAIL fwd_hit: got %0b exp 1", fwd_hit_o); end
    ld_addr_i = 64'h8000_1240;
    #1;
    n_checks++; if (fwd_hit_o !== 1'b0) begin n_fail++; $display("FAIL fwd_miss: got %0b exp 0", fwd_hit_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_drain();
    test_full();
    test_flush();
    test_stall();
    test_back_to_back_wrap();
`ifdef CVA6_SQ_FWD_EN
    test_fwd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_store_queue.md
COMMIT_STORE_QUEUE -- requirements
Module: commit_store_queue

Interface
REQ-001: Parameter DEPTH, default 8, number of store entries (power of two, >=2).
REQ-002: Parameter ADDR_W, default 64, physical address width.
REQ-003: Parameter DATA_W, default 64, store data width; byte-enable width is DATA_W/8.
REQ-004: clk_i  in  1  clock; one clock domain, all state updates on its rising edge.
REQ-005: rst_ni  in  1  reset, synchronous and active-low.
REQ-006: flush_i  in  1  discard all speculative (uncommitted) entries.
REQ-007: valid_i  in  1  push request from the store unit.
REQ-008: ready_o  out  1  queue can accept a push this cycle.
REQ-009: addr_i / data_i / be_i  in  ADDR_W / DATA_W / DATA_W/8  push payload.
REQ-010: commit_i  in  1  commit the oldest speculative entry.
REQ-011: commit_ready_o  out  1  at least one speculative entry exists.
REQ-012: req_o  out  1  drain request to the write-back data cache.
REQ-013: gnt_i  in  1  cache accepts the drain request.
REQ-014: addr_o / data_o / be_o  out  ADDR_W / DATA_W / DATA_W/8  head-entry payload.
REQ-015: empty_o  out  1  no valid entries of any kind.

Function
REQ-016: Three pointers (rd, cm, wr) of log2(DEPTH)+1 bits each, with wrap bit; committed count = cm-rd, speculative count = wr-cm.
REQ-017: ready_o = (total count < DEPTH); a push occurs on valid_i && ready_o && !flush_i and advances wr by 1.
REQ-018: commit_ready_o = (speculative count > 0); commit_i while commit_ready_o is 0 is ignored, with no pointer change.
REQ-019: Drain FSM states IDLE and REQ; IDLE->REQ when committed count > 0; in REQ req_o=1; REQ->IDLE on gnt_i when committed count becomes 0, otherwise stay in REQ.
REQ-020: On req_o && gnt_i, rd advances by 1 and the next head payload appears in the following cycle.
REQ-021: addr_o, data_o and be_o hold the head entry and remain stable while req_o=1 and gnt_i=0.
REQ-022: Latency: a push in cycle N can be committed in N+1; a commit in cycle N raises req_o in N+1 at the earliest.
REQ-023: Push, commit and drain in the same cycle are all honoured; counts update by their net effect.
REQ-024: Full queue with a drain in the same cycle: ready_o stays 0 in that cycle; no bypass of a push.
REQ-025: flush_i sets wr := cm after any same-cycle commit (a commit in the flush cycle is honoured); committed entries and the drain continue unaffected.
REQ-026: A push in the flush cycle is dropped.
REQ-027: Pointer wrap: the wrap bit distinguishes full (equal index, differing wrap bit) from empty.
REQ-028: empty_o = (rd == wr).

Reset
REQ-029: On rst_ni=0 at a clock edge: rd=cm=wr=0, FSM=IDLE.
REQ-030: Outputs during and after reset: ready_o=1, commit_ready_o=0, req_o=0, empty_o=1.
REQ-031: Reset mid-transaction abandons a pending req_o; entry storage is not cleared.

Configuration
REQ-032: Macro CVA6_SQ_FWD_EN, when defined, adds:
- input ld_addr_i [ADDR_W-1:0];
- output fwd_hit_o, =1 when any valid entry (committed or speculative) matches ld_addr_i[11:3], using the same cycle's state.
REQ-033: When CVA6_SQ_FWD_EN is undefined, these ports and their logic are absent.

Structure
REQ-034: Typedef sq_entry_t {addr, data, be} and constant SQ_DEPTH_DEFAULT belong in std_cache_pkg.
REQ-035: Sub-module commit_store_queue_fwd holds the per-entry page-offset comparators; it is instantiated only under CVA6_SQ_FWD_EN.

Verification
REQ-036: Reset, then push 3 entries (addr 0x8000_0000/08/10), commit 3, gnt_i held 1 -> req_o in the cycle after the first commit; addresses drain in order; empty_o=1 after the 3rd grant.
REQ-037: Push 8 entries with no commit -> ready_o=0 after the 8th; a 9th valid_i is not accepted; commit_ready_o=1.
REQ-038: 4 speculative entries, commit_i and flush_i in the same cycle -> 1 entry drains; wr==cm; commit_ready_o=0.
REQ-039: Committed head with gnt_i=0 for 5 cycles -> req_o=1 and addr_o/data_o/be_o stable throughout; rd advances only on the grant cycle.
REQ-040: Full queue, then push+commit+drain in the same cycle, repeated 20 times -> pointers wrap with no loss or duplication; scoreboard order matches.
REQ-041: With CVA6_SQ_FWD_EN: entry addr 0x8000_1238, ld_addr_i 0x9000_0238 -> fwd_hit_o=1; ld_addr_i 0x8000_1240 -> fwd_hit_o=0.
